// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit per clock, LSB first.
// A single full-adder cell plus a carry/borrow flip-flop works through
// WIDTH-bit operands held in shift registers. Subtraction is done as
// a + ~b + ~cin, and the final carry is inverted to give the borrow.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          request; accepted in IDLE or DONE (ignored while busy)
//   mode           0 = add (a+b+cin), 1 = subtract (a-b-cin)
//   a, b, cin      operands and carry/borrow-in, sampled with start
//   busy           high while bits are being processed
//   done           one-cycle pulse; result/cout/ovf valid from this cycle
//   result         sum/difference modulo 2^WIDTH (partial while busy)
//   cout           carry-out (add) or borrow-out (sub)
//   ovf            signed two's-complement overflow
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic            c;
  logic            mode_q;
  logic [CW-1:0]   cnt;

  logic            s, c_nxt, last, accept;

  // Full-adder cell on the current LSBs.
  always_comb begin
    s      = sh_a[0] ^ sh_b[0] ^ c;
    c_nxt  = (sh_a[0] & sh_b[0]) | (sh_a[0] & c) | (sh_b[0] & c);
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && (state != RUN);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      sh_a   <= '0;
      sh_b   <= '0;
      c      <= 1'b0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      // Flags are registered from the next state so they line up with it.
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
      if (accept) begin
        sh_a   <= a;
        sh_b   <= mode ? ~b : b;
        c      <= mode ? ~cin : cin;
        mode_q <= mode;
        result <= '0;
        cout   <= 1'b0;
        ovf    <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        sh_a   <= sh_a >> 1;
        sh_b   <= sh_b >> 1;
        c      <= c_nxt;
        result <= {s, result[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
        if (last) begin
          // On the MSB bit, c is the carry into the MSB, so overflow is
          // carry-in-to-MSB xor carry-out-of-MSB.
          cout <= mode_q ? ~c_nxt : c_nxt;
          ovf  <= c ^ c_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: directed WIDTH=8 vector table with
// handshake timing checks, protocol corner sequences, and an exhaustive
// back-to-back WIDTH=4 sweep against a behavioural reference.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, mode8, cin8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, res8;
  logic       start4, mode4, cin4, busy4, done4, co4, ov4;
  logic [3:0] a4, b4, res4;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .result(res8), .cout(co8), .ovf(ov8)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .result(res4), .cout(co4), .ovf(ov4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       m;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] r;
    logic       co, ov;
  } vec_t;

  vec_t vecs[10];

  // One WIDTH=8 operation with full handshake timing checks. Operands are
  // scrambled right after acceptance to show they are not re-sampled.
  task automatic run8(input logic m, input logic [7:0] ai, input logic [7:0] bi,
                      input logic ci, input logic [7:0] er, input logic eco,
                      input logic eov, input string nm);
    int bad;
    bad = 0;
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = ai; b8 = bi; cin8 = ci;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin start8 = 1'b0; a8 = ~ai; b8 = ~bi; cin8 = ~ci; end
      if (!busy8 || done8) bad++;
    end
    chk({nm, " busy8cyc"}, bad, 0);
    @(negedge clk);
    chk({nm, " done"}, {busy8, done8}, 2'b01);
    chk({nm, " result"}, {co8, ov8, res8}, {eco, eov, er});
    @(negedge clk);
    chk({nm, " done1cyc/hold"}, {busy8, done8, co8, ov8, res8}, {2'b00, eco, eov, er});
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; mode4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (2) @(negedge clk);
    chk("reset8", {busy8, done8, co8, ov8, res8}, 12'h0);
    chk("reset4", {busy4, done4, co4, ov4, res4}, 8'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run8(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].r,
           vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));

    // start with new operands on bit 3 of a running op is ignored
    @(negedge clk);
    start8 = 1; mode8 = 0; a8 = 8'h12; b8 = 8'h34; cin8 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start8 = (i == 3);
      if (i == 3) begin mode8 = 1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; end
    end
    start8 = 0;
    @(negedge clk);
    chk("ignore_start", {busy8, done8, co8, ov8, res8}, {4'b0100, 8'h46});
    @(negedge clk);
    chk("ignore_start idle", {busy8, done8}, 2'b00);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    start8 = 1; mode8 = 0; a8 = 8'h01; b8 = 8'h02; cin8 = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 0;
    end
    chk("b2b first", {done8, co8, ov8, res8}, {3'b100, 8'h03});
    start8 = 1; mode8 = 1; a8 = 8'h10; b8 = 8'h01; cin8 = 0;
    @(negedge clk);
    start8 = 0;
    chk("b2b accepted", {busy8, done8}, 2'b10);
    repeat (8) @(negedge clk);
    chk("b2b second", {busy8, done8, co8, ov8, res8}, {4'b0100, 8'h0F});

    // reset on bit 4 aborts with no done
    @(negedge clk);
    start8 = 1; mode8 = 0; a8 = 8'h0F; b8 = 8'h00; cin8 = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort outputs", {busy8, done8, co8, ov8, res8}, 12'h0);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8 || busy8) seen++;
      end
      chk("abort no done", seen, 0);
    end
    run8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "after_abort");

    // WIDTH=4 exhaustive, back-to-back
    @(negedge clk);
    for (int k = 0; k < 1024; k++) begin
      logic       m, ci, eco, eov;
      logic [3:0] av, bv, er;
      int         sum;
      m = k[9]; av = k[8:5]; bv = k[4:1]; ci = k[0];
      if (!m) begin
        sum = int'(av) + int'(bv) + int'(ci);
        er  = sum[3:0];
        eco = sum[4];
        eov = (av[3] == bv[3]) && (er[3] != av[3]);
      end else begin
        sum = int'(av) - int'(bv) - int'(ci);
        er  = sum[3:0];
        eco = (int'(av) < int'(bv) + int'(ci));
        eov = (av[3] != bv[3]) && (er[3] != av[3]);
      end
      start4 = 1; mode4 = m; a4 = av; b4 = bv; cin4 = ci;
      @(negedge clk);
      start4 = 0;
      repeat (4) @(negedge clk);
      chk($sformatf("w4 m%0d a%0h b%0h c%0d", m, av, bv, ci),
          {busy4, done4, co4, ov4, res4}, {2'b01, eco, eov, er});
    end
    @(negedge clk);
    chk("w4 idle", {busy4, done4}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
